fp_norm_round_pipe: RTL
=======================

Name: fp_norm_round_pipe

Overview:
- Parametrised, two-stage pipelined normalise-and-round back end for the FPU adder datapath.
- Takes the aligned/added significand, provisional exponent and special-case bypass from the add stage. Produces a packed IEEE-754 result plus exception flags.
- Handles carry-out, cancellation, gradual underflow and the denormal-to-normal round carry, and all four rounding modes.
- Uses an elastic valid/ready handshake so the FPU can stall without losing operations.

Parameters:
- EXP_W, 8, exponent width
- FRAC_W, 23, stored fraction width; significand input is FRAC_W+5 bits: carry, hidden, FRAC_W fraction, guard, round, sticky

Ports:
- clk  in  1  clock
- rst  in  1  synchronous active-high reset
- in_valid  in  1  input operation valid
- in_ready  out  1  stage can accept
- rm  in  2  rounding mode: 00 RNE, 01 toward -inf, 10 toward +inf, 11 toward zero
- sign  in  1  result sign
- is_inf_nan  in  1  special-value bypass
- inf_nan_frac  in  FRAC_W  fraction used when bypassing
- temp_exp  in  EXP_W  provisional biased exponent
- cal_frac  in  FRAC_W+5  raw significand, MSB is carry
- out_valid  out  1  result valid
- out_ready  in  1  downstream accepts
- s  out  1+EXP_W+FRAC_W  packed result {sign, exp, frac}
- flag_ovf  out  1  overflow
- flag_unf  out  1  underflow: tiny and inexact
- flag_inx  out  1  inexact

Behaviour:
- Reset (sync, rst=1 at clk edge):
  - both stage valids, out_valid, s and all flags go to 0.
  - In-flight operations are discarded.
  - in_ready is 1 in the first cycle after reset.
- Handshake:
  - Transfer occurs on a cycle with valid & ready.
  - Stage k loads when its register is empty or stage k+1 loads/drains.
  - in_ready = ~v1 | ~v2 | out_ready, combinational, with no dependency on in_valid.
  - s and flags are held stable while out_valid & ~out_ready.
  - Latency is 2 cycles. Throughput is 1 per cycle. Order is preserved. Simultaneous accept and drain in the same cycle is legal.
- Stage 1 (normalise), registers sign, rm, is_inf_nan, inf_nan_frac, exp0, frac0[FRAC_W+3:0]:
  - Carry set (cal_frac MSB = 1):
    - frac0 = cal_frac[MSB:1], with sticky frac0[0] = cal_frac[1] | cal_frac[0].
    - exp0 = temp_exp + 1.
  - Otherwise, lz = leading-zero count of cal_frac[MSB-1:0]:
    - cal_frac all zero: exp0 = 0, frac0 = 0.
    - temp_exp > lz: frac0 = cal_frac[MSB-1:0] << lz, exp0 = temp_exp - lz.
    - Else (denormal): exp0 = 0; frac0 = cal_frac[MSB-1:0] << (temp_exp - 1) if temp_exp != 0, otherwise unshifted.
- Stage 2 (round and pack), using lsb = frac0[3], g = frac0[2], r = frac0[1], st = frac0[0]:
  - inc is:
    - RNE: g & (r | st | lsb)
    - -inf: sign & (g | r | st)
    - +inf: ~sign & (g | r | st)
    - RZ: 0
  - fr = {0, frac0[FRAC_W+3:3]} + inc, FRAC_W+2 bits.
  - Exponent adjustment:
    - fr MSB set: exp = exp0 + 1.
    - else exp0 = 0 and fr[FRAC_W] set (denormal rounds to normal): exp = 1.
    - else exp = exp0.
  - Overflow when exp0 or exp is all ones. Overflow result by rm and sign:
    - RNE: inf
    - RZ: max finite
    - -inf: max finite if positive, -inf if negative
    - +inf: +inf if positive, max finite if negative
  - flag_ovf = 1 and flag_inx = 1 on overflow.
  - flag_inx = g | r | st otherwise.
  - flag_unf = (exp == 0) & inexact.
  - is_inf_nan bypass: s = {sign, all ones, inf_nan_frac}, all flags 0.
  - Zero result keeps the input sign.

Optional Feature:
- Macro FP_NORM_FTZ_EN.
- Defined: any non-bypass result with final exp == 0 and nonzero fraction is flushed to signed zero, with flag_unf = 1 and flag_inx = 1.
- Undefined: gradual underflow as above.
- Pipeline timing is identical in both builds.

Test Plan:
- Carry: temp_exp=0x7F, cal_frac=28'h8000000, rm=00, out_ready=1 -> 2 cycles later s=0x40000000, all flags 0.
- Cancellation: temp_exp=0x7F, cal_frac=28'h0000008 -> s=0x34000000, flags 0.
- RNE rounding:
  - cal_frac=28'h4000004, temp_exp=0x7F -> s=0x3F800000, inx=1.
  - cal_frac=28'h400000C -> s=0x3F800002, inx=1.
- Overflow: temp_exp=0xFE, cal_frac=28'h8000000:
  - rm=00 -> 0x7F800000, ovf=1, inx=1.
  - rm=11 -> 0x7F7FFFFF.
  - rm=01 with sign=1 -> 0xFF800000.
- Denormal: temp_exp=0x01, cal_frac=28'h2000000:
  - default build -> 0x00400000, unf=0.
  - FP_NORM_FTZ_EN build -> 0x00000000, unf=1.
- Backpressure: 4 back-to-back inputs with out_ready=0 for 3 cycles -> in_ready drops after 2 accepted, all 4 results emerge in order, none lost or duplicated.
- Reset mid-flight: rst asserted with both stages full -> out_valid=0 next cycle, no stale output after release.

Source files
------------

// File: rtl/fp_norm_round_pipe.sv
// fp_norm_round_pipe: two-stage normalise / round / pack back end for the FPU adder.
// Stage 1 normalises the raw significand (carry-out, cancellation, gradual underflow).
// Stage 2 rounds in the selected mode, handles overflow and packs the IEEE-754 result.
// An elastic valid/ready handshake lets the downstream stall without dropping operations.
// Optional build macro FP_NORM_FTZ_EN: results that would be subnormal are flushed
// to a signed zero with underflow and inexact raised; pipeline timing is unchanged.
module fp_norm_round_pipe #(
    parameter int EXP_W  = 8,
    parameter int FRAC_W = 23
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    in_valid,
    output logic                    in_ready,
    input  logic [1:0]              rm,
    input  logic                    sign,
    input  logic                    is_inf_nan,
    input  logic [FRAC_W-1:0]       inf_nan_frac,
    input  logic [EXP_W-1:0]        temp_exp,
    input  logic [FRAC_W+4:0]       cal_frac,
    output logic                    out_valid,
    input  logic                    out_ready,
    output logic [EXP_W+FRAC_W:0]   s,
    output logic                    flag_ovf,
    output logic                    flag_unf,
    output logic                    flag_inx
);

    localparam int SIG_W  = FRAC_W + 5;            // carry, hidden, fraction, g, r, st
    localparam int BODY_W = FRAC_W + 4;            // hidden, fraction, g, r, st
    localparam int FR_W   = FRAC_W + 2;            // rounded significand incl. carry
    localparam int LZ_W   = $clog2(BODY_W + 1);
    localparam int CMP_W  = (EXP_W > LZ_W) ? EXP_W : LZ_W;
    localparam int PK_W   = EXP_W + FRAC_W + 1;
    localparam int RES_W  = PK_W + 3;              // {s, ovf, unf, inx}
    localparam logic [EXP_W-1:0] EXP_ONES = '1;

    // Leading-zero count of the significand below the carry bit.
    function automatic logic [LZ_W-1:0] lzc(input logic [BODY_W-1:0] v);
        logic [LZ_W-1:0] n;
        logic            done;
        n    = '0;
        done = 1'b0;
        for (int i = BODY_W - 1; i >= 0; i--) begin
            if (!done) begin
                if (v[i]) done = 1'b1;
                else      n = n + LZ_W'(1);
            end
        end
        return n;
    endfunction

    // Rounding, exponent adjustment, overflow saturation and packing.
    function automatic logic [RES_W-1:0] round_pack(
        input logic              sgn,
        input logic [1:0]        mode,
        input logic [EXP_W-1:0]  e0,
        input logic [BODY_W-1:0] f0
    );
        logic               lsb, g, r, st, inc, inexact, ovf, unf, inx;
        logic [FR_W-1:0]    fr;
        logic [EXP_W-1:0]   e;
        logic [PK_W-1:0]    res;
        lsb     = f0[3];
        g       = f0[2];
        r       = f0[1];
        st      = f0[0];
        inexact = g | r | st;
        case (mode)
            2'b00:   inc = g & (r | st | lsb);
            2'b01:   inc = sgn & inexact;
            2'b10:   inc = ~sgn & inexact;
            default: inc = 1'b0;
        endcase
        fr = {1'b0, f0[BODY_W-1:3]} + FR_W'(inc);
        if (fr[FR_W-1])                      e = e0 + EXP_W'(1);
        else if (e0 == '0 && fr[FRAC_W])    e = EXP_W'(1);
        else                                 e = e0;
        ovf = (e0 == EXP_ONES) || (e == EXP_ONES);
        if (ovf) begin
            // Saturate to infinity or the largest finite value depending on direction.
            case (mode)
                2'b00:   res = {sgn, EXP_ONES, {FRAC_W{1'b0}}};
                2'b01:   res = sgn ? {sgn, EXP_ONES, {FRAC_W{1'b0}}}
                               : {sgn, EXP_ONES - EXP_W'(1), {FRAC_W{1'b1}}};
                2'b10:   res = sgn ? {sgn, EXP_ONES - EXP_W'(1), {FRAC_W{1'b1}}}
                               : {sgn, EXP_ONES, {FRAC_W{1'b0}}};
                default: res = {sgn, EXP_ONES - EXP_W'(1), {FRAC_W{1'b1}}};
            endcase
            unf = 1'b0;
            inx = 1'b1;
        end else begin
            res = {sgn, e, fr[FRAC_W-1:0]};
            unf = (e == '0) & inexact;
            inx = inexact;
`ifdef FP_NORM_FTZ_EN
            if (e == '0 && fr[FRAC_W-1:0] != '0) begin
                res = {sgn, {(PK_W-1){1'b0}}};
                unf = 1'b1;
                inx = 1'b1;
            end
`endif
        end
        return {res, ovf, unf, inx};
    endfunction

    logic                   vld_p1, vld_p2;
    logic                   ld1, ld2;
    logic [BODY_W-1:0]      body;
    logic [LZ_W-1:0]        lz;
    logic [EXP_W-1:0]       exp_n;
    logic [BODY_W-1:0]      frac_n;
    logic                   sign_p1, is_inf_nan_p1;
    logic [1:0]             rm_p1;
    logic [FRAC_W-1:0]      inf_nan_frac_p1;
    logic [EXP_W-1:0]       exp_p1;
    logic [BODY_W-1:0]      frac_p1;
    logic [RES_W-1:0]       res_p1;

    assign ld2       = ~vld_p2 | out_ready;
    assign ld1       = ~vld_p1 | ld2;
    assign in_ready  = ld1;
    assign out_valid = vld_p2;

    // Normalise: shift out carry, remove leading zeros, or stop at the subnormal exponent.
    always_comb begin
        body   = cal_frac[SIG_W-2:0];
        lz     = lzc(body);
        exp_n  = '0;
        frac_n = '0;
        if (cal_frac[SIG_W-1]) begin
            frac_n    = cal_frac[SIG_W-1:1];
            frac_n[0] = cal_frac[1] | cal_frac[0];
            exp_n     = temp_exp + EXP_W'(1);
        end else if (body == '0) begin
            exp_n  = '0;
            frac_n = '0;
        end else if (CMP_W'(temp_exp) > CMP_W'(lz)) begin
            frac_n = body << lz;
            exp_n  = temp_exp - EXP_W'(lz);
        end else begin
            exp_n = '0;
            if (temp_exp != '0) frac_n = body << (temp_exp - EXP_W'(1));
            else                frac_n = body;
        end
    end

    // Round and pack, or pass the special value straight through.
    always_comb begin
        if (is_inf_nan_p1) res_p1 = {sign_p1, EXP_ONES, inf_nan_frac_p1, 3'b000};
        else               res_p1 = round_pack(sign_p1, rm_p1, exp_p1, frac_p1);
    end

    // Stage valid bits advance whenever the next stage frees up.
    always_ff @(posedge clk) begin
        if (rst) begin
            vld_p1 <= 1'b0;
            vld_p2 <= 1'b0;
        end else begin
            if (ld1) vld_p1 <= in_valid;
            if (ld2) vld_p2 <= vld_p1;
        end
    end

    // Stage 1 operand register: captures the normalised operation.
    always_ff @(posedge clk) begin
        if (ld1 && in_valid) begin
            sign_p1         <= sign;
            rm_p1           <= rm;
            is_inf_nan_p1   <= is_inf_nan;
            inf_nan_frac_p1 <= inf_nan_frac;
            exp_p1          <= exp_n;
            frac_p1         <= frac_n;
        end
    end

    // Stage 2 result register: held while the consumer stalls.
    always_ff @(posedge clk) begin
        if (rst) begin
            s        <= '0;
            flag_ovf <= 1'b0;
            flag_unf <= 1'b0;
            flag_inx <= 1'b0;
        end else if (ld2 && vld_p1) begin
            s        <= res_p1[RES_W-1:3];
            flag_ovf <= res_p1[2];
            flag_unf <= res_p1[1];
            flag_inx <= res_p1[0];
        end
    end

endmodule
